rename_multiway: RTL and testbench

//  Superscalar register renamer for the out-of-order core. Maps up to RENAME_WIDTH instructions per cycle

---
 rtl/rename_multiway_pkg.sv | 56 +++++
 rtl/rename_multiway_if.sv | 31 +++
 rtl/rename_multiway_free_fifo.sv | 110 +++++++++++
 rtl/rename_multiway.sv | 168 ++++++++++++++++
 tb/tb_rename_multiway.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rename_multiway_pkg.sv
// Shared types and helpers for the multi-way register renamer.
// Widths, the RAT entry layout and free-list pointer arithmetic.
package rename_multiway_pkg;

    function automatic int clog2w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int RENAME_WIDTH = 2;
    localparam int NUM_WAKEUP   = 4;
    localparam int NUM_FREE     = 2;
    localparam int NUM_ARCH     = 32;
    localparam int NUM_PHYS     = 64;
    localparam int XLEN         = 32;

    localparam int TAG_W    = clog2w(NUM_PHYS);
    localparam int AREG_W   = clog2w(NUM_ARCH);
    localparam int FL_DEPTH = NUM_PHYS - NUM_ARCH;
    localparam int PTR_W    = clog2w(FL_DEPTH);
    localparam int CNT_W    = clog2w(FL_DEPTH + 1);

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [AREG_W-1:0] areg_t;
    typedef logic [XLEN-1:0]   data_t;
    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef struct packed {
        tag_t  tag;
        data_t value;
        logic  ready;
    } rat_entry_t;

    localparam tag_t INVALID_TAG = '0;

    // (p + n) mod FL_DEPTH, valid for n <= FL_DEPTH
    function automatic ptr_t ptr_add(input ptr_t p, input cnt_t n);
        logic [CNT_W:0] s;
        s = (CNT_W+1)'(p) + (CNT_W+1)'(n);
        if (s >= (CNT_W+1)'(FL_DEPTH))
            s = s - (CNT_W+1)'(FL_DEPTH);
        return ptr_t'(s);
    endfunction

    // (a - b) mod FL_DEPTH
    function automatic cnt_t ptr_dist(input ptr_t a, input ptr_t b);
        ptr_t d;
        if (a >= b) begin
            d = a - b;
            return cnt_t'(d);
        end
        d = b - a;
        return cnt_t'(FL_DEPTH) - cnt_t'(d);
    endfunction

endpackage

// File: rtl/rename_multiway_if.sv
// Rename-group handshake bundle between the front end and the renamer.
// master: front end (drives group), slave: renamer (returns tags/sources).
interface rename_multiway_if;
    import rename_multiway_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    areg_t [RENAME_WIDTH-1:0] arch_rd;
    areg_t [RENAME_WIDTH-1:0] arch_rs1;
    areg_t [RENAME_WIDTH-1:0] arch_rs2;
    tag_t  [RENAME_WIDTH-1:0] phys_rd;
    tag_t  [RENAME_WIDTH-1:0] phys_rs1;
    tag_t  [RENAME_WIDTH-1:0] phys_rs2;
    logic  [RENAME_WIDTH-1:0] rs1_ready;
    logic  [RENAME_WIDTH-1:0] rs2_ready;
    data_t [RENAME_WIDTH-1:0] rs1_value;
    data_t [RENAME_WIDTH-1:0] rs2_value;

    modport master (
        output in_valid, arch_rd, arch_rs1, arch_rs2,
        input  in_ready, phys_rd, phys_rs1, phys_rs2,
        input  rs1_ready, rs2_ready, rs1_value, rs2_value
    );

    modport slave (
        input  in_valid, arch_rd, arch_rs1, arch_rs2,
        output in_ready, phys_rd, phys_rs1, phys_rs2,
        output rs1_ready, rs2_ready, rs1_value, rs2_value
    );

endinterface

// File: rtl/rename_multiway_free_fifo.sv
// Circular free list: multi-pop at head, multi-push at tail, commit pointer
// for flush rollback. Ports: alloc mask/tags, push, commit count, flush, count.
module rename_multiway_free_fifo
    import rename_multiway_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alloc_en_i,
    input  logic [RENAME_WIDTH-1:0]  alloc_mask_i,
    output tag_t [RENAME_WIDTH-1:0]  alloc_tag_o,
    input  logic [NUM_FREE-1:0]      push_valid_i,
    input  tag_t [NUM_FREE-1:0]      push_tag_i,
    input  cnt_t                     commit_n_i,
    input  logic                     flush_i,
    output cnt_t                     count_o
);

    tag_t fl_q [FL_DEPTH];
    tag_t fl_d [FL_DEPTH];
    ptr_t head_q, head_d;
    ptr_t tail_q, tail_d;
    ptr_t commit_q, commit_d;
    cnt_t count_q, count_d;
    cnt_t pop_n, push_n;
    logic dbl_free;

    // Lane k takes the entry at head + (number of earlier lanes with rd)
    always_comb begin
        pop_n = '0;
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            alloc_tag_o[k] = INVALID_TAG;
            if (alloc_mask_i[k]) begin
                alloc_tag_o[k] = fl_q[ptr_add(head_q, pop_n)];
                pop_n = pop_n + cnt_t'(1);
            end
        end
    end

    always_comb begin
        fl_d   = fl_q;
        tail_d = tail_q;
        push_n = '0;
        for (int p = 0; p < NUM_FREE; p++) begin
            if (push_valid_i[p]) begin
                fl_d[tail_d] = push_tag_i[p];
                tail_d = ptr_add(tail_d, cnt_t'(1));
                push_n = push_n + cnt_t'(1);
            end
        end
        commit_d = ptr_add(commit_q, commit_n_i);
        if (flush_i) begin
            // Uncommitted allocations return to the free pool
            head_d  = commit_d;
            count_d = count_q + push_n + ptr_dist(head_q, commit_d);
        end else if (alloc_en_i) begin
            head_d  = ptr_add(head_q, pop_n);
            count_d = count_q + push_n - pop_n;
        end else begin
            head_d  = head_q;
            count_d = count_q + push_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FL_DEPTH; i++)
                fl_q[i] <= tag_t'(NUM_ARCH + i);
            head_q   <= '0;
            tail_q   <= '0;
            commit_q <= '0;
            count_q  <= cnt_t'(FL_DEPTH);
        end else begin
            fl_q     <= fl_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            commit_q <= commit_d;
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;

    // A pushed tag must not already sit in the free region or repeat
    always_comb begin
        dbl_free = 1'b0;
        for (int p = 0; p < NUM_FREE; p++) begin
            if (push_valid_i[p]) begin
                for (int q = 0; q < p; q++)
                    if (push_valid_i[q] && push_tag_i[q] == push_tag_i[p])
                        dbl_free = 1'b1;
                for (int i = 0; i < FL_DEPTH; i++)
                    if (cnt_t'(i) < count_q &&
                        fl_q[ptr_add(head_q, cnt_t'(i))] == push_tag_i[p])
                        dbl_free = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!dbl_free)
                else $fatal(1, "free list: double free");
            assert (count_d <= cnt_t'(FL_DEPTH))
                else $fatal(1, "free list: push beyond capacity");
            assert (count_q <= cnt_t'(FL_DEPTH))
                else $fatal(1, "free list: count above depth");
        end
    end

endmodule

// File: rtl/rename_multiway.sv
// Superscalar renamer: SRAT/CRAT, intra-group bypass, wakeup capture, stall.
// Ports: clk, reset, bus (rename group), wakeup/free/retire ports, flush.
module rename_multiway
    import rename_multiway_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    rename_multiway_if.slave        bus,
    input  logic  [NUM_WAKEUP-1:0]  wakeup_valid,
    input  tag_t  [NUM_WAKEUP-1:0]  wakeup_tag,
    input  data_t [NUM_WAKEUP-1:0]  wakeup_value,
    input  logic  [NUM_FREE-1:0]    free_valid,
    input  tag_t  [NUM_FREE-1:0]    free_tag,
    input  logic  [NUM_FREE-1:0]    retire_valid,
    input  areg_t [NUM_FREE-1:0]    retire_rd,
    input  tag_t  [NUM_FREE-1:0]    retire_tag,
    input  data_t [NUM_FREE-1:0]    retire_value,
    input  logic                    flush
);

    rat_entry_t srat_q [NUM_ARCH];
    rat_entry_t srat_d [NUM_ARCH];
    rat_entry_t crat_q [NUM_ARCH];
    rat_entry_t crat_d [NUM_ARCH];

    areg_t [RENAME_WIDTH-1:0] lane_rd;
    logic  [RENAME_WIDTH-1:0] has_rd;
    tag_t  [RENAME_WIDTH-1:0] alloc_tag;
    logic  [NUM_FREE-1:0]     push_valid;
    cnt_t need, fl_count, commit_n;
    logic accept;
    logic wk_dup, wk_on_ready;

    assign lane_rd = bus.arch_rd;

    always_comb begin
        need = '0;
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            has_rd[k] = lane_rd[k] != '0;
            if (has_rd[k])
                need = need + cnt_t'(1);
        end
    end

    // Whole group or nothing; flush blocks acceptance
    assign bus.in_ready = (fl_count >= need) && !flush;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        for (int p = 0; p < NUM_FREE; p++)
            push_valid[p] = free_valid[p] && (free_tag[p] != INVALID_TAG);
    end

    rename_multiway_free_fifo u_free_fifo (
        .clk          (clk),
        .reset        (reset),
        .alloc_en_i   (accept),
        .alloc_mask_i (has_rd),
        .alloc_tag_o  (alloc_tag),
        .push_valid_i (push_valid),
        .push_tag_i   (free_tag),
        .commit_n_i   (commit_n),
        .flush_i      (flush),
        .count_o      (fl_count)
    );

    // Youngest earlier lane writing the source wins over SRAT + wakeup
    function automatic rat_entry_t lookup(input int k, input areg_t a);
        rat_entry_t e;
        e = srat_q[a];
        for (int w = 0; w < NUM_WAKEUP; w++)
            if (wakeup_valid[w] && wakeup_tag[w] == e.tag &&
                e.tag != INVALID_TAG) begin
                e.ready = 1'b1;
                e.value = wakeup_value[w];
            end
        for (int j = 0; j < RENAME_WIDTH; j++)
            if (j < k && has_rd[j] && lane_rd[j] == a) begin
                e.tag   = alloc_tag[j];
                e.ready = 1'b0;
            end
        if (!e.ready)
            e.value = '0;
        return e;
    endfunction

    always_comb begin
        rat_entry_t e1, e2;
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            e1 = lookup(k, bus.arch_rs1[k]);
            e2 = lookup(k, bus.arch_rs2[k]);
            bus.phys_rd[k]   = alloc_tag[k];
            bus.phys_rs1[k]  = e1.tag;
            bus.rs1_ready[k] = e1.ready;
            bus.rs1_value[k] = e1.value;
            bus.phys_rs2[k]  = e2.tag;
            bus.rs2_ready[k] = e2.ready;
            bus.rs2_value[k] = e2.value;
        end
    end

    always_comb begin
        crat_d   = crat_q;
        commit_n = '0;
        for (int p = 0; p < NUM_FREE; p++) begin
            if (retire_valid[p] && retire_rd[p] != '0) begin
                crat_d[retire_rd[p]] = '{tag: retire_tag[p],
                                         value: retire_value[p],
                                         ready: 1'b1};
                commit_n = commit_n + cnt_t'(1);
            end
        end

        srat_d = srat_q;
        for (int i = 1; i < NUM_ARCH; i++)
            for (int w = 0; w < NUM_WAKEUP; w++)
                if (wakeup_valid[w] && wakeup_tag[w] == srat_q[i].tag) begin
                    srat_d[i].ready = 1'b1;
                    srat_d[i].value = wakeup_value[w];
                end
        // Later lanes overwrite earlier ones; same-cycle wakeup is dropped
        if (accept)
            for (int k = 0; k < RENAME_WIDTH; k++)
                if (has_rd[k])
                    srat_d[lane_rd[k]] = '{tag: alloc_tag[k],
                                           value: '0,
                                           ready: 1'b0};
        if (flush)
            srat_d = crat_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                srat_q[i] <= '{tag: tag_t'(i), value: '0, ready: 1'b1};
                crat_q[i] <= '{tag: tag_t'(i), value: '0, ready: 1'b1};
            end
        end else begin
            srat_q <= srat_d;
            crat_q <= crat_d;
        end
    end

    always_comb begin
        wk_dup      = 1'b0;
        wk_on_ready = 1'b0;
        for (int w = 0; w < NUM_WAKEUP; w++) begin
            if (wakeup_valid[w]) begin
                for (int v = 0; v < w; v++)
                    if (wakeup_valid[v] && wakeup_tag[v] == wakeup_tag[w])
                        wk_dup = 1'b1;
                for (int i = 1; i < NUM_ARCH; i++)
                    if (srat_q[i].tag == wakeup_tag[w] && srat_q[i].ready)
                        wk_on_ready = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!wk_dup)
                else $fatal(1, "rename: duplicate wakeup tags");
            assert (!wk_on_ready)
                else $fatal(1, "rename: wakeup to ready entry");
        end
    end

endmodule

// File: tb/tb_rename_multiway.sv
// Directed self-checking bench for rename_multiway.
// Inputs driven at negedge, combinational outputs sampled 1 time unit later.
module tb_rename_multiway;
    import rename_multiway_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic  [NUM_WAKEUP-1:0] wakeup_valid;
    tag_t  [NUM_WAKEUP-1:0] wakeup_tag;
    data_t [NUM_WAKEUP-1:0] wakeup_value;
    logic  [NUM_FREE-1:0]   free_valid;
    tag_t  [NUM_FREE-1:0]   free_tag;
    logic  [NUM_FREE-1:0]   retire_valid;
    areg_t [NUM_FREE-1:0]   retire_rd;
    tag_t  [NUM_FREE-1:0]   retire_tag;
    data_t [NUM_FREE-1:0]   retire_value;
    logic                   flush;

    int n_pass  = 0;
    int n_total = 0;

    rename_multiway_if bus ();

    rename_multiway dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .wakeup_valid (wakeup_valid),
        .wakeup_tag   (wakeup_tag),
        .wakeup_value (wakeup_value),
        .free_valid   (free_valid),
        .free_tag     (free_tag),
        .retire_valid (retire_valid),
        .retire_rd    (retire_rd),
        .retire_tag   (retire_tag),
        .retire_value (retire_value),
        .flush        (flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string t, input logic [63:0] got,
                         input logic [63:0] exp);
        n_total++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", t, got, exp);
    endtask

    task automatic clear_inputs();
        bus.in_valid = 1'b0;
        bus.arch_rd  = '0;
        bus.arch_rs1 = '0;
        bus.arch_rs2 = '0;
        wakeup_valid = '0;
        wakeup_tag   = '0;
        wakeup_value = '0;
        free_valid   = '0;
        free_tag     = '0;
        retire_valid = '0;
        retire_rd    = '0;
        retire_tag   = '0;
        retire_value = '0;
        flush        = 1'b0;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic lane(input int k, input int rd, input int rs1,
                        input int rs2);
        bus.arch_rd[k]  = areg_t'(rd);
        bus.arch_rs1[k] = areg_t'(rs1);
        bus.arch_rs2[k] = areg_t'(rs2);
    endtask

    task automatic chk_rs1(input string t, input int k, input int tag,
                           input int rdy, input int val);
        check({t, ".tag"}, 64'(bus.phys_rs1[k]), 64'(tag));
        check({t, ".rdy"}, 64'(bus.rs1_ready[k]), 64'(rdy));
        check({t, ".val"}, 64'(bus.rs1_value[k]), 64'(val));
    endtask

    // Idle cycle that reads SRAT[a] through lane 0 rs1
    task automatic probe(input string t, input int a, input int tag,
                         input int rdy, input int val);
        next_cycle();
        bus.arch_rs1[0] = areg_t'(a);
        #1;
        chk_rs1(t, 0, tag, rdy, val);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int q[$];
        int e0, e1, p0, p1;

        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        probe("rst.x5", 5, 5, 1, 0);

        next_cycle();
        bus.in_valid = 1'b1;
        lane(0, 1, 0, 0);
        lane(1, 2, 1, 0);
        #1;
        check("t1.in_ready", 64'(bus.in_ready), 64'(1));
        check("t1.prd0", 64'(bus.phys_rd[0]), 64'(32));
        check("t1.prd1", 64'(bus.phys_rd[1]), 64'(33));
        chk_rs1("t1.l0rs1", 0, 0, 1, 0);
        chk_rs1("t1.l1rs1", 1, 32, 0, 0);
        probe("t1.x1", 1, 32, 0, 0);
        probe("t1.x2", 2, 33, 0, 0);

        next_cycle();
        bus.in_valid = 1'b1;
        lane(0, 3, 1, 0);
        lane(1, 0, 3, 2);
        wakeup_valid[0] = 1'b1;
        wakeup_tag[0]   = tag_t'(32);
        wakeup_value[0] = 32'h55;
        #1;
        chk_rs1("t2.l0rs1", 0, 32, 1, 'h55);
        chk_rs1("t2.l1rs1", 1, 34, 0, 0);
        check("t2.prd0", 64'(bus.phys_rd[0]), 64'(34));
        check("t2.prd1", 64'(bus.phys_rd[1]), 64'(0));
        check("t2.l1rs2.tag", 64'(bus.phys_rs2[1]), 64'(33));
        check("t2.l1rs2.rdy", 64'(bus.rs2_ready[1]), 64'(0));
        probe("t2.x1", 1, 32, 1, 'h55);
        probe("t2.x3", 3, 34, 0, 0);

        for (int g = 0; g < 14; g++) begin
            next_cycle();
            bus.in_valid = 1'b1;
            lane(0, 4, 0, 0);
            lane(1, 5, 0, 0);
            #1;
            check("t3.drain0", 64'(bus.phys_rd[0]), 64'(35 + 2 * g));
            check("t3.drain1", 64'(bus.phys_rd[1]), 64'(36 + 2 * g));
        end
        next_cycle();
        bus.in_valid = 1'b1;
        lane(0, 6, 0, 0);
        lane(1, 7, 0, 0);
        #1;
        check("t3.stall", 64'(bus.in_ready), 64'(0));
        next_cycle();
        bus.in_valid = 1'b1;
        lane(0, 6, 0, 0);
        lane(1, 7, 0, 0);
        free_valid[0] = 1'b1;
        free_tag[0]   = tag_t'(5);
        #1;
        check("t3.stall_free", 64'(bus.in_ready), 64'(0));
        probe("t3.x6", 6, 6, 1, 0);
        probe("t3.x4", 4, 61, 0, 0);
        next_cycle();
        bus.in_valid = 1'b1;
        lane(0, 6, 0, 0);
        lane(1, 7, 0, 0);
        #1;
        check("t3.accept", 64'(bus.in_ready), 64'(1));
        check("t3.prd0", 64'(bus.phys_rd[0]), 64'(63));
        check("t3.prd1", 64'(bus.phys_rd[1]), 64'(5));
        probe("t3.x7", 7, 5, 0, 0);

        do_reset();
        for (int g = 0; g < 4; g++) begin
            next_cycle();
            bus.in_valid = 1'b1;
            lane(0, 8, 0, 0);
            lane(1, 9, 0, 0);
        end
        next_cycle();
        bus.in_valid = 1'b1;
        lane(0, 3, 0, 0);
        lane(1, 3, 3, 0);
        #1;
        check("t4.prd0", 64'(bus.phys_rd[0]), 64'(40));
        check("t4.prd1", 64'(bus.phys_rd[1]), 64'(41));
        chk_rs1("t4.bypass", 1, 40, 0, 0);
        probe("t4.x3_last", 3, 41, 0, 0);
        for (int g = 0; g < 4; g++) begin
            next_cycle();
            retire_valid    = 2'b11;
            retire_rd[0]    = areg_t'(8);
            retire_tag[0]   = tag_t'(32 + 2 * g);
            retire_value[0] = data_t'(132 + 2 * g);
            retire_rd[1]    = areg_t'(9);
            retire_tag[1]   = tag_t'(33 + 2 * g);
            retire_value[1] = data_t'(133 + 2 * g);
        end
        next_cycle();
        retire_valid[0] = 1'b1;
        retire_rd[0]    = areg_t'(3);
        retire_tag[0]   = tag_t'(40);
        retire_value[0] = 32'd7;
        next_cycle();
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        lane(0, 10, 0, 0);
        #1;
        check("t4.flush_rdy", 64'(bus.in_ready), 64'(0));
        probe("t4.x3", 3, 40, 1, 7);
        probe("t4.x9", 9, 39, 1, 139);
        probe("t4.x10", 10, 10, 1, 0);
        next_cycle();
        bus.in_valid = 1'b1;
        lane(0, 12, 0, 0);
        #1;
        check("t4.realloc_rdy", 64'(bus.in_ready), 64'(1));
        check("t4.realloc", 64'(bus.phys_rd[0]), 64'(41));

        do_reset();
        q = {};
        for (int i = 0; i < FL_DEPTH; i++)
            q.push_back(NUM_ARCH + i);
        p0 = 0;
        p1 = 0;
        for (int c = 0; c < 34; c++) begin
            next_cycle();
            bus.in_valid = 1'b1;
            lane(0, 1, 0, 0);
            lane(1, 2, 0, 0);
            if (c > 0) begin
                free_valid  = 2'b11;
                free_tag[0] = tag_t'(p0);
                free_tag[1] = tag_t'(p1);
            end
            #1;
            e0 = q.pop_front();
            e1 = q.pop_front();
            check("t5.rdy", 64'(bus.in_ready), 64'(1));
            check("t5.prd0", 64'(bus.phys_rd[0]), 64'(e0));
            check("t5.prd1", 64'(bus.phys_rd[1]), 64'(e1));
            if (c > 0) begin
                q.push_back(p0);
                q.push_back(p1);
            end
            p0 = e0;
            p1 = e1;
        end
        next_cycle();
        free_valid  = 2'b11;
        free_tag[0] = tag_t'(p0);
        free_tag[1] = tag_t'(p1);
        q.push_back(p0);
        q.push_back(p1);
        for (int g = 0; g < 16; g++) begin
            next_cycle();
            bus.in_valid = 1'b1;
            lane(0, 3, 0, 0);
            lane(1, 4, 0, 0);
            #1;
            e0 = q.pop_front();
            e1 = q.pop_front();
            check("t5.full_rdy", 64'(bus.in_ready), 64'(1));
            check("t5.full0", 64'(bus.phys_rd[0]), 64'(e0));
            check("t5.full1", 64'(bus.phys_rd[1]), 64'(e1));
        end
        next_cycle();
        bus.in_valid = 1'b1;
        lane(0, 5, 0, 0);
        #1;
        check("t5.empty", 64'(bus.in_ready), 64'(0));

        do_reset();
        next_cycle();
        bus.in_valid = 1'b1;
        lane(0, 1, 0, 0);
        lane(1, 2, 0, 0);
        #1;
        check("t6.prd0", 64'(bus.phys_rd[0]), 64'(32));
        check("t6.prd1", 64'(bus.phys_rd[1]), 64'(33));
        next_cycle();
        retire_valid[0] = 1'b1;
        retire_rd[0]    = areg_t'(1);
        retire_tag[0]   = tag_t'(32);
        retire_value[0] = 32'h22;
        next_cycle();
        flush           = 1'b1;
        bus.in_valid    = 1'b1;
        lane(0, 4, 1, 2);
        wakeup_valid[0] = 1'b1;
        wakeup_tag[0]   = tag_t'(33);
        wakeup_value[0] = 32'h99;
        #1;
        check("t6.flush_rdy", 64'(bus.in_ready), 64'(0));
        check("t6.rs2.rdy", 64'(bus.rs2_ready[0]), 64'(1));
        check("t6.rs2.val", 64'(bus.rs2_value[0]), 64'(32'h99));
        check("t6.rs1.rdy", 64'(bus.rs1_ready[0]), 64'(0));
        probe("t6.x1", 1, 32, 1, 'h22);
        probe("t6.x2", 2, 2, 1, 0);
        probe("t6.x4", 4, 4, 1, 0);
        next_cycle();
        bus.in_valid = 1'b1;
        lane(0, 5, 0, 0);
        #1;
        check("t6.realloc", 64'(bus.phys_rd[0]), 64'(33));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
